pd_stage_nw: RTL and testbench

N-wide predict/decode stage. It owns the fetch PC, the speculative global history register (GHR) and a gshare PHT with FETCH_WIDTH read ports. It consumes same-cycle BTB/RAS lookup results for the current fetch block and selects the first predicted-taken lane. It produces the next PC and registers a fetch-block descriptor behind a valid/ready handshake to the decode queue. Execute-stage redirect restores PC and GHR and flushes the output register.

---
 rtl/pd_pkg.sv | 75 +++++++
 rtl/pd_stage_nw_pht.sv | 41 ++++
 rtl/pd_stage_nw.sv | 142 ++++++++++++++
 tb/tb_pd_stage_nw.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pd_pkg.sv
// Shared types and helpers for the N-wide predict/decode stage.
// Helpers operate on fixed maximum widths so any legal FETCH_WIDTH/GHR_SIZE
// instantiation can zero-extend into them and truncate the result back.
package pd_pkg;

  localparam int MAX_FW     = 8;
  localparam int MAX_GHR    = 32;
  localparam int LANE_IDX_W = 3;
  localparam int COUNT_W    = 4;

  // Two-bit saturating direction counter; MSB is the taken prediction.
  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_STRONG_NT = 2'b00;
  localparam ctr_t CTR_WEAK_NT   = 2'b01;
  localparam ctr_t CTR_STRONG_T  = 2'b11;

  // Result of a lowest-set-bit search across the fetch lanes.
  typedef struct packed {
    logic                  found;
    logic [LANE_IDX_W-1:0] idx;
  } first_t;

  // Lowest set bit of vec, with a flag telling whether any bit was set.
  function automatic first_t first_one(input logic [MAX_FW-1:0] vec);
    first_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int j = MAX_FW - 1; j >= 0; j--) begin
      if (vec[j]) begin
        r.found = 1'b1;
        r.idx   = LANE_IDX_W'(j);
      end
    end
    return r;
  endfunction

  // Shift 'count' new outcomes into the history. The earliest outcome
  // (bits[0]) lands at bit 0, so a block's outcomes keep their lane order
  // reading from the LSB upward.
  function automatic logic [MAX_GHR-1:0] ghr_shift(input logic [MAX_GHR-1:0] ghr,
                                                   input logic [MAX_FW-1:0]  bits,
                                                   input logic [COUNT_W-1:0] count);
    logic [MAX_GHR-1:0] r;
    r = ghr;
    for (int j = 0; j < MAX_FW; j++) begin
      if (COUNT_W'(j) < count) begin
        r = {r[MAX_GHR-2:0], 1'b0};
      end
    end
    for (int j = 0; j < MAX_FW; j++) begin
      if (COUNT_W'(j) < count) begin
        r[j] = bits[j];
      end
    end
    return r;
  endfunction

  // Saturating counter step toward the resolved direction.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != CTR_STRONG_T) begin
        r = c + 2'd1;
      end
    end else begin
      if (c != CTR_STRONG_NT) begin
        r = c - 2'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pd_stage_nw_pht.sv
// gshare pattern history table: FETCH_WIDTH combinational read ports and a
// single synchronous training port. Reads see the pre-training value when the
// same entry is trained in the same cycle.
module pht_nport
  import pd_pkg::*;
#(
  parameter int FETCH_WIDTH = 4,
  parameter int PHT_ADDRESS = 9
) (
  input  logic                                    CLK,
  input  logic                                    reset,
  input  logic [FETCH_WIDTH-1:0][PHT_ADDRESS-1:0] rd_index,
  output ctr_t [FETCH_WIDTH-1:0]                  rd_ctr,
  input  logic                                    train,
  input  logic [PHT_ADDRESS-1:0]                  train_index,
  input  logic                                    train_taken
);

  localparam int PHT_DEPTH = 1 << PHT_ADDRESS;

  ctr_t ctr_mem [PHT_DEPTH];

  // Per-lane lookups straight out of the counter array.
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      rd_ctr[i] = ctr_mem[rd_index[i]];
    end
  end

  // Reset every counter to weakly not-taken; otherwise step the trained entry.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int e = 0; e < PHT_DEPTH; e++) begin
        ctr_mem[e] <= CTR_WEAK_NT;
      end
    end else if (train) begin
      ctr_mem[train_index] <= ctr_next(ctr_mem[train_index], train_taken);
    end
  end

endmodule

// File: rtl/pd_stage_nw.sv
// N-wide predict/decode stage. Owns the fetch PC and speculative global
// history, looks up gshare directions for every lane of the current block,
// picks the first predicted-taken lane and registers a block descriptor for
// the decode queue. An execute redirect restores PC/history and drops the
// descriptor in flight.
module pd_stage_nw
  import pd_pkg::*;
#(
  parameter int              FETCH_WIDTH = 4,
  parameter int              XLEN        = 32,
  parameter int              PHT_ADDRESS = 9,
  parameter int              GHR_SIZE    = 9,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                               CLK,
  input  logic                               reset,
  output logic [XLEN-1:0]                    fetch_pc,
  input  logic [FETCH_WIDTH-1:0]             btb_hit,
  input  logic [FETCH_WIDTH-1:0]             btb_is_branch,
  input  logic [FETCH_WIDTH-1:0]             btb_is_ret,
  input  logic [FETCH_WIDTH*XLEN-1:0]        btb_target,
  input  logic [XLEN-1:0]                    ras_top,
  input  logic                               redirect,
  input  logic [XLEN-1:0]                    redirect_pc,
  input  logic [GHR_SIZE-1:0]                restore_ghr,
  input  logic                               update_pht,
  input  logic [PHT_ADDRESS-1:0]             rb_pht_index,
  input  logic                               actual_taken,
  output logic                               pd_valid,
  input  logic                               pd_ready,
  output logic [XLEN-1:0]                    pd_pc,
  output logic [FETCH_WIDTH-1:0]             pd_lane_valid,
  output logic [FETCH_WIDTH-1:0]             pd_pred_taken,
  output logic [XLEN-1:0]                    pd_pred_target,
  output logic [FETCH_WIDTH*PHT_ADDRESS-1:0] pd_pht_index,
  output logic [GHR_SIZE-1:0]                pd_ghr_snap
);

  logic [XLEN-1:0]                        pc;
  logic [XLEN-1:0]                        next_pc;
  logic [GHR_SIZE-1:0]                    ghr;
  logic [GHR_SIZE-1:0]                    ghr_next;
  logic [FETCH_WIDTH-1:0][PHT_ADDRESS-1:0] lane_index;
  ctr_t [FETCH_WIDTH-1:0]                 lane_ctr;
  logic [FETCH_WIDTH-1:0]                 lane_taken;
  logic [FETCH_WIDTH-1:0]                 lane_valid;
  logic [FETCH_WIDTH-1:0]                 pred_taken;
  first_t                                 first_taken;
  logic [MAX_FW-1:0]                      hist_bits;
  logic [COUNT_W-1:0]                     hist_count;
  logic                                   advance;

  assign fetch_pc = pc;
  assign advance  = !pd_valid || pd_ready;

  // gshare index per lane. Adding 4*i to the PC only touches bits above [1:0],
  // so the word-index slice of pc+4*i equals pc's slice plus i (mod 2^PHT_ADDRESS).
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_index[i] = PHT_ADDRESS'(ghr) ^ (pc[PHT_ADDRESS+1:2] + PHT_ADDRESS'(i));
    end
  end

  pht_nport #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .PHT_ADDRESS (PHT_ADDRESS)
  ) u_pht (
    .CLK         (CLK),
    .reset       (reset),
    .rd_index    (lane_index),
    .rd_ctr      (lane_ctr),
    .train       (update_pht),
    .train_index (rb_pht_index),
    .train_taken (actual_taken)
  );

  // Pick the first taken lane, derive the next PC, the surviving lanes and
  // the conditional-branch outcomes that feed the speculative history.
  always_comb begin
    lane_taken = '0;
    lane_valid = '0;
    pred_taken = '0;
    hist_bits  = '0;
    hist_count = '0;
    next_pc    = pc + XLEN'(4 * FETCH_WIDTH);
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_taken[i] = btb_hit[i] && (btb_is_ret[i] || !btb_is_branch[i] || lane_ctr[i][1]);
    end
    first_taken = first_one(MAX_FW'(lane_taken));
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_valid[i] = !first_taken.found || (LANE_IDX_W'(i) <= first_taken.idx);
      pred_taken[i] = first_taken.found && (LANE_IDX_W'(i) == first_taken.idx);
      if (pred_taken[i]) begin
        next_pc = btb_is_ret[i] ? ras_top : btb_target[i*XLEN +: XLEN];
      end
      if (lane_valid[i] && btb_hit[i] && btb_is_branch[i]) begin
        hist_bits[hist_count[LANE_IDX_W-1:0]] = lane_ctr[i][1];
        hist_count = hist_count + COUNT_W'(1);
      end
    end
  end

  assign ghr_next = GHR_SIZE'(ghr_shift(MAX_GHR'(ghr), hist_bits, hist_count));

  // Fetch PC and speculative history: redirect restores, advance moves on, stall holds.
  always_ff @(posedge CLK) begin
    if (reset) begin
      pc  <= RESET_PC;
      ghr <= '0;
    end else if (redirect) begin
      pc  <= redirect_pc;
      ghr <= restore_ghr;
    end else if (advance) begin
      pc  <= next_pc;
      ghr <= ghr_next;
    end
  end

  // Descriptor register toward decode: loads on advance, dropped by redirect.
  always_ff @(posedge CLK) begin
    if (reset) begin
      pd_valid       <= 1'b0;
      pd_pc          <= '0;
      pd_lane_valid  <= '0;
      pd_pred_taken  <= '0;
      pd_pred_target <= '0;
      pd_pht_index   <= '0;
      pd_ghr_snap    <= '0;
    end else if (redirect) begin
      pd_valid <= 1'b0;
    end else if (advance) begin
      pd_valid       <= 1'b1;
      pd_pc          <= pc;
      pd_lane_valid  <= lane_valid;
      pd_pred_taken  <= pred_taken;
      pd_pred_target <= next_pc;
      pd_pht_index   <= lane_index;
      pd_ghr_snap    <= ghr;
    end
  end

endmodule

// File: tb/tb_pd_stage_nw.sv
// Directed bench for pd_stage_nw: a block-level reference model tracks the
// expected PC, history, counters and descriptor, and is compared every cycle;
// hand-computed literals pin the key scenarios.
module tb_pd_stage_nw;

  logic         CLK = 1'b0;
  logic         reset;
  logic [31:0]  fetch_pc;
  logic [3:0]   btb_hit;
  logic [3:0]   btb_is_branch;
  logic [3:0]   btb_is_ret;
  logic [127:0] btb_target;
  logic [31:0]  ras_top;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic [8:0]   restore_ghr;
  logic         update_pht;
  logic [8:0]   rb_pht_index;
  logic         actual_taken;
  logic         pd_valid;
  logic         pd_ready;
  logic [31:0]  pd_pc;
  logic [3:0]   pd_lane_valid;
  logic [3:0]   pd_pred_taken;
  logic [31:0]  pd_pred_target;
  logic [35:0]  pd_pht_index;
  logic [8:0]   pd_ghr_snap;

  int checks = 0;
  int errors = 0;

  pd_stage_nw #(
    .FETCH_WIDTH (4),
    .XLEN        (32),
    .PHT_ADDRESS (9),
    .GHR_SIZE    (9),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .CLK            (CLK),
    .reset          (reset),
    .fetch_pc       (fetch_pc),
    .btb_hit        (btb_hit),
    .btb_is_branch  (btb_is_branch),
    .btb_is_ret     (btb_is_ret),
    .btb_target     (btb_target),
    .ras_top        (ras_top),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .restore_ghr    (restore_ghr),
    .update_pht     (update_pht),
    .rb_pht_index   (rb_pht_index),
    .actual_taken   (actual_taken),
    .pd_valid       (pd_valid),
    .pd_ready       (pd_ready),
    .pd_pc          (pd_pc),
    .pd_lane_valid  (pd_lane_valid),
    .pd_pred_taken  (pd_pred_taken),
    .pd_pred_target (pd_pred_target),
    .pd_pht_index   (pd_pht_index),
    .pd_ghr_snap    (pd_ghr_snap)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] hit, input logic [3:0] br, input logic [3:0] ret,
                               input logic [127:0] tgt, input logic [31:0] ras);
    btb_hit       = hit;
    btb_is_branch = br;
    btb_is_ret    = ret;
    btb_target    = tgt;
    ras_top       = ras;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference model state
  bit          m_init = 0;
  logic [31:0] m_pc;
  logic [8:0]  m_ghr;
  int          m_pht [512];
  logic        m_valid;
  logic [31:0] m_pd_pc;
  logic [3:0]  m_lv;
  logic [3:0]  m_pt;
  logic [31:0] m_tgt;
  logic [35:0] m_idx;
  logic [8:0]  m_snap;

  // Model: evaluate the block from the rules, train, then redirect/advance.
  always @(posedge CLK) begin : model
    logic [31:0] lpc;
    logic [31:0] nxt;
    logic [35:0] idx_all;
    int          idx [4];
    int          found;
    int          k;
    int          last;
    int          gi;
    bit          tk;
    int          preds [$];
    if (reset) begin
      m_init  = 1;
      m_pc    = 32'h0;
      m_ghr   = '0;
      for (int e = 0; e < 512; e++) m_pht[e] = 1;
      m_valid = 0;
      m_pd_pc = '0; m_lv = '0; m_pt = '0; m_tgt = '0; m_idx = '0; m_snap = '0;
    end else begin
      found = 0;
      k = 0;
      for (int i = 0; i < 4; i++) begin
        lpc = m_pc + 32'(4 * i);
        idx[i] = (int'(m_ghr) ^ int'(lpc[10:2])) & 511;
        idx_all[i*9 +: 9] = 9'(idx[i]);
        tk = btb_hit[i] && (btb_is_ret[i] || !btb_is_branch[i] || m_pht[idx[i]] >= 2);
        if (tk && found == 0) begin
          found = 1;
          k = i;
        end
      end
      last = (found != 0) ? k : 3;
      preds.delete();
      for (int i = 0; i <= last; i++) begin
        if (btb_hit[i] && btb_is_branch[i]) preds.push_back((m_pht[idx[i]] >= 2) ? 1 : 0);
      end
      gi = int'(m_ghr) << preds.size();
      for (int j = 0; j < preds.size(); j++) gi = gi | (preds[j] << j);
      gi = gi & 'h1FF;
      nxt = (found != 0) ? (btb_is_ret[k] ? ras_top : btb_target[k*32 +: 32]) : m_pc + 32'd16;
      if (update_pht) begin
        if (actual_taken) m_pht[rb_pht_index] = (m_pht[rb_pht_index] < 3) ? m_pht[rb_pht_index] + 1 : 3;
        else              m_pht[rb_pht_index] = (m_pht[rb_pht_index] > 0) ? m_pht[rb_pht_index] - 1 : 0;
      end
      if (redirect) begin
        m_pc    = redirect_pc;
        m_ghr   = restore_ghr;
        m_valid = 0;
      end else if (!m_valid || pd_ready) begin
        m_valid = 1;
        m_pd_pc = m_pc;
        m_lv    = (found != 0) ? 4'((1 << (k + 1)) - 1) : 4'hF;
        m_pt    = (found != 0) ? 4'(1 << k) : 4'h0;
        m_tgt   = nxt;
        m_idx   = idx_all;
        m_snap  = m_ghr;
        m_pc    = nxt;
        m_ghr   = 9'(gi);
      end
    end
  end

  // Compare DUT against the model on every falling edge once reset was seen.
  always @(negedge CLK) begin
    if (m_init) begin
      checkOutput("model_fetch_pc", 64'(fetch_pc), 64'(m_pc));
      checkOutput("model_pd_valid", 64'(pd_valid), 64'(m_valid));
      if (m_valid) begin
        checkOutput("model_pd_pc", 64'(pd_pc), 64'(m_pd_pc));
        checkOutput("model_lane_valid", 64'(pd_lane_valid), 64'(m_lv));
        checkOutput("model_pred_taken", 64'(pd_pred_taken), 64'(m_pt));
        checkOutput("model_pred_target", 64'(pd_pred_target), 64'(m_tgt));
        checkOutput("model_pht_index", 64'(pd_pht_index), 64'(m_idx));
        checkOutput("model_ghr_snap", 64'(pd_ghr_snap), 64'(m_snap));
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence.
  initial begin
    reset = 1'b1;
    redirect = 1'b0; redirect_pc = '0; restore_ghr = '0;
    update_pht = 1'b0; rb_pht_index = '0; actual_taken = 1'b0;
    pd_ready = 1'b1;
    applyStimulus(4'h0, 4'h0, 4'h0, '0, '0);
    step();
    step();
    checkOutput("reset_fetch_pc", 64'(fetch_pc), 64'h0);
    checkOutput("reset_pd_valid", 64'(pd_valid), 64'h0);
    checkOutput("reset_ghr_snap", 64'(pd_ghr_snap), 64'h0);
    checkOutput("reset_lane_valid", 64'(pd_lane_valid), 64'h0);

    // Idle run; meanwhile train index 134 (lane 2 of block 0x210) up to 11.
    reset = 1'b0;
    update_pht = 1'b1; rb_pht_index = 9'd134; actual_taken = 1'b1;
    step();
    checkOutput("idle_pd_pc0", 64'(pd_pc), 64'h0);
    checkOutput("idle_fetch_pc1", 64'(fetch_pc), 64'h10);
    checkOutput("idle_lane_valid", 64'(pd_lane_valid), 64'hF);
    checkOutput("idle_pred_taken", 64'(pd_pred_taken), 64'h0);
    step();
    checkOutput("idle_fetch_pc2", 64'(fetch_pc), 64'h20);
    checkOutput("idle_ghr_snap", 64'(pd_ghr_snap), 64'h0);
    update_pht = 1'b0;
    step();
    step();
    checkOutput("jump_fetch_pc", 64'(fetch_pc), 64'h40);

    // Unconditional jump in lane 1.
    applyStimulus(4'b0010, 4'b0000, 4'b0000, {32'h0, 32'h0, 32'h200, 32'h0}, '0);
    step();
    checkOutput("jump_pd_pc", 64'(pd_pc), 64'h40);
    checkOutput("jump_lane_valid", 64'(pd_lane_valid), 64'h3);
    checkOutput("jump_pred_taken", 64'(pd_pred_taken), 64'h2);
    checkOutput("jump_target", 64'(pd_pred_target), 64'h200);
    checkOutput("jump_next_fetch", 64'(fetch_pc), 64'h200);
    applyStimulus(4'h0, 4'h0, 4'h0, '0, '0);
    step();
    checkOutput("jump_ghr_unchanged", 64'(pd_ghr_snap), 64'h0);
    checkOutput("cond_fetch_pc", 64'(fetch_pc), 64'h210);

    // Conditional branches in lanes 0 (counter 01) and 2 (counter 11).
    applyStimulus(4'b0101, 4'b0101, 4'b0000, {32'h0, 32'h300, 32'h0, 32'h0}, '0);
    step();
    checkOutput("cond_lane_valid", 64'(pd_lane_valid), 64'h7);
    checkOutput("cond_pred_taken", 64'(pd_pred_taken), 64'h4);
    checkOutput("cond_target", 64'(pd_pred_target), 64'h300);
    checkOutput("cond_next_fetch", 64'(fetch_pc), 64'h300);

    // Return in lane 0.
    applyStimulus(4'b0001, 4'b0000, 4'b0001, '0, 32'h1234);
    step();
    checkOutput("ret_pd_pc", 64'(pd_pc), 64'h300);
    checkOutput("cond_ghr_after", 64'(pd_ghr_snap), 64'h002);
    checkOutput("ret_pred_taken", 64'(pd_pred_taken), 64'h1);
    checkOutput("ret_target", 64'(pd_pred_target), 64'h1234);
    checkOutput("ret_next_fetch", 64'(fetch_pc), 64'h1234);

    // Three-cycle stall, then a redirect while stalled.
    applyStimulus(4'h0, 4'h0, 4'h0, '0, '0);
    pd_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput("stall_pd_valid", 64'(pd_valid), 64'h1);
      checkOutput("stall_pd_pc", 64'(pd_pc), 64'h300);
      checkOutput("stall_target", 64'(pd_pred_target), 64'h1234);
      checkOutput("stall_fetch_pc", 64'(fetch_pc), 64'h1234);
    end
    redirect = 1'b1; redirect_pc = 32'h800; restore_ghr = 9'h155;
    step();
    checkOutput("redir_pd_valid", 64'(pd_valid), 64'h0);
    checkOutput("redir_fetch_pc", 64'(fetch_pc), 64'h800);
    redirect = 1'b0;
    pd_ready = 1'b1;
    step();
    checkOutput("redir_next_valid", 64'(pd_valid), 64'h1);
    checkOutput("redir_next_pd_pc", 64'(pd_pc), 64'h800);
    checkOutput("redir_ghr_snap", 64'(pd_ghr_snap), 64'h155);

    // Training index 5: block at 0x14 with ghr 0 reads index 5 in lane 0.
    redirect = 1'b1; redirect_pc = 32'h14; restore_ghr = 9'h0;
    step();
    redirect = 1'b0;
    applyStimulus(4'b0001, 4'b0001, 4'b0000, '0, '0);
    update_pht = 1'b1; rb_pht_index = 9'd5; actual_taken = 1'b1;
    step();
    checkOutput("train_same_cycle_pc", 64'(pd_pc), 64'h14);
    checkOutput("train_same_cycle_idx", 64'(pd_pht_index[8:0]), 64'h5);
    checkOutput("train_same_cycle_taken", 64'(pd_pred_taken), 64'h0);
    checkOutput("train_same_cycle_lanes", 64'(pd_lane_valid), 64'hF);
    applyStimulus(4'h0, 4'h0, 4'h0, '0, '0);
    step();
    step();
    // Not-taken training together with a redirect back to 0x14.
    actual_taken = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h14; restore_ghr = 9'h0;
    step();
    checkOutput("train_redir_fetch", 64'(fetch_pc), 64'h14);
    update_pht = 1'b0;
    redirect = 1'b0;
    applyStimulus(4'b0001, 4'b0001, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h500}, '0);
    step();
    checkOutput("trained_pred_taken", 64'(pd_pred_taken), 64'h1);
    checkOutput("trained_lane_valid", 64'(pd_lane_valid), 64'h1);
    checkOutput("trained_target", 64'(pd_pred_target), 64'h500);
    checkOutput("trained_next_fetch", 64'(fetch_pc), 64'h500);
    applyStimulus(4'h0, 4'h0, 4'h0, '0, '0);
    step();
    checkOutput("trained_ghr_snap", 64'(pd_ghr_snap), 64'h001);

    // PC wrap at the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; restore_ghr = 9'h0;
    step();
    redirect = 1'b0;
    step();
    checkOutput("wrap_pd_pc", 64'(pd_pc), 64'hFFFF_FFF8);
    checkOutput("wrap_next_fetch", 64'(fetch_pc), 64'h8);
    checkOutput("wrap_pht_index", 64'(pd_pht_index), 64'({9'd1, 9'd0, 9'h1FF, 9'h1FE}));

    // Reset in the middle of a stall drops the descriptor.
    pd_ready = 1'b0;
    step();
    checkOutput("prereset_hold_pc", 64'(pd_pc), 64'hFFFF_FFF8);
    reset = 1'b1;
    update_pht = 1'b1; rb_pht_index = 9'd5; actual_taken = 1'b1;
    step();
    checkOutput("midstall_reset_valid", 64'(pd_valid), 64'h0);
    checkOutput("midstall_reset_fetch", 64'(fetch_pc), 64'h0);
    reset = 1'b0;
    update_pht = 1'b0;
    pd_ready = 1'b1;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
